// File: rtl/cache_pkg.sv
// Shared cache definitions: refill FSM state type and set/tag geometry.
package cache_pkg;

  localparam int unsigned SET_BITS = 4;
  localparam int unsigned TAG_BITS = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FILL,
    ST_WR_REQ
  } refill_state_t;

  // States in which a memory transaction is outstanding and the watchdog runs.
  function automatic logic is_mem_state(input refill_state_t s);
    return (s == ST_RD_REQ) || (s == ST_RD_WAIT) || (s == ST_WR_REQ);
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_timer.sv
// Saturating watchdog counter for the refill controller.
module refill_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT);

  logic [W-1:0] count;

  // Count cycles while enabled, restart on clear, hold once the limit is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill and write-through controller between the data cache and memory.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  hit_i,
  output logic                  stall_o,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  fill_we_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  timeout_o
);

  refill_state_t         state;
  refill_state_t         next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  timeout_q;
  logic                  expired;
  logic                  abort;

  refill_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (next_state != state),
    .enable (is_mem_state(state)),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the request address/data in IDLE and the returned read word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_we_i) begin
            addr_q <= req_addr_i;
            data_q <= req_wdata_i;
          end else if (req_valid_i && !hit_i) begin
            addr_q <= req_addr_i;
          end
        end
        ST_RD_REQ: if (mem_gnt_i && mem_rvalid_i) data_q <= mem_rdata_i;
        ST_RD_WAIT: if (mem_rvalid_i) data_q <= mem_rdata_i;
        default: ;
      endcase
    end
  end

  // Sticky watchdog error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else if (abort) begin
      timeout_q <= 1'b1;
    end
  end

  // Next-state logic; a memory handshake in the expiry cycle still completes.
  always_comb begin
    next_state = state;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid_i && req_we_i) begin
          next_state = ST_WR_REQ;
        end else if (req_valid_i && !hit_i) begin
          next_state = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mem_gnt_i && mem_rvalid_i) begin
          next_state = ST_FILL;
        end else if (mem_gnt_i) begin
          next_state = ST_RD_WAIT;
        end else if (expired) begin
          next_state = ST_IDLE;
          abort      = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (mem_rvalid_i) begin
          next_state = ST_FILL;
        end else if (expired) begin
          next_state = ST_IDLE;
          abort      = 1'b1;
        end
      end
      ST_FILL: next_state = ST_IDLE;
      ST_WR_REQ: begin
        if (mem_gnt_i) begin
          next_state = ST_IDLE;
        end else if (expired) begin
          next_state = ST_IDLE;
          abort      = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode; memory-side outputs depend on state and latched values only.
  always_comb begin
    stall_o      = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    fill_we_o    = 1'b0;
    fill_addr_o  = '0;
    fill_data_o  = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state)
      ST_IDLE: stall_o = req_valid_i & (req_we_i | ~hit_i);
      ST_RD_REQ: begin
        stall_o      = 1'b1;
        mem_req_o    = 1'b1;
        mem_addr_o   = addr_q;
        resp_valid_o = abort;
      end
      ST_RD_WAIT: begin
        stall_o      = 1'b1;
        resp_valid_o = abort;
      end
      ST_FILL: begin
        fill_we_o    = 1'b1;
        fill_addr_o  = addr_q;
        fill_data_o  = data_q;
        resp_valid_o = 1'b1;
        resp_rdata_o = data_q;
      end
      ST_WR_REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = data_q;
      end
      default: ;
    endcase
  end

  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl with a word-memory reference model.
module tb_cache_refill_ctrl;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, hit;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, fill_we, mem_req, mem_we, timeout;
  logic [31:0] resp_rdata, fill_addr, fill_data, mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic timeout_exp = 1'b0;
  logic [31:0] mem_model [logic [31:0]];

  cache_refill_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .hit_i(hit),
    .stall_o(stall), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .fill_we_o(fill_we), .fill_addr_o(fill_addr), .fill_data_o(fill_data),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  task automatic junk_req();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    hit       = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic quiet();
    req_valid = 1'b0; req_we = 1'b0; hit = 1'b0;
    req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_fill_we"}, fill_we, 0);
    chk({tag, "_fill_addr"}, fill_addr, 0);
    chk({tag, "_fill_data"}, fill_data, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  // Read hit: one request cycle, then an idle cycle; memory never touched.
  task automatic read_hit(input logic [31:0] a);
    for (int c = 0; c < 2; c++) begin
      quiet();
      if (c == 0) begin
        req_valid = 1'b1; req_we = 1'b0; hit = 1'b1; req_addr = a;
      end
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge clk);
      chk("hit_stall", stall, 0);
      chk("hit_mem_req", mem_req, 0);
      chk("hit_resp_valid", resp_valid, 0);
      chk("hit_fill_we", fill_we, 0);
      chk("hit_timeout", timeout, timeout_exp);
      next_cycle();
    end
  endtask

  // Read miss: grant at cycle g, data at cycle r (r >= g >= 1), fill/response at r+1.
  task automatic read_miss(input logic [31:0] a, input int g, input int r);
    logic [31:0] d;
    d = mem_rd(a);
    for (int c = 0; c <= r + 1; c++) begin
      if (c == 0) begin
        req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; req_addr = a; req_wdata = $urandom;
      end else begin
        junk_req();
      end
      mem_gnt    = (c == g);
      mem_rvalid = (c == r) || (c < g) || (c == r + 1) ? ((c == r) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      mem_rdata  = (c == r) ? d : $urandom;
      @(negedge clk);
      chk("rd_stall", stall, (c <= r));
      chk("rd_mem_req", mem_req, (c >= 1 && c <= g));
      if (c >= 1 && c <= g) begin
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, a);
      end
      chk("rd_fill_we", fill_we, (c == r + 1));
      chk("rd_resp_valid", resp_valid, (c == r + 1));
      if (c == r + 1) begin
        chk("rd_fill_addr", fill_addr, a);
        chk("rd_fill_data", fill_data, d);
        chk("rd_resp_rdata", resp_rdata, d);
      end
      next_cycle();
    end
    quiet();
  endtask

  // Store: posted write granted at cycle g (g >= 1), idle again at g+1.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input int g);
    for (int c = 0; c <= g + 1; c++) begin
      if (c == 0) begin
        req_valid = 1'b1; req_we = 1'b1; hit = 1'($urandom_range(0, 1));
        req_addr = a; req_wdata = d;
      end else if (c <= g) begin
        junk_req();
      end else begin
        req_valid = 1'b0;
      end
      mem_gnt    = (c == g);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge clk);
      chk("wr_stall", stall, (c <= g));
      chk("wr_mem_req", mem_req, (c >= 1 && c <= g));
      chk("wr_mem_we", mem_we, (c >= 1 && c <= g));
      if (c >= 1 && c <= g) begin
        chk("wr_mem_addr", mem_addr, a);
        chk("wr_mem_wdata", mem_wdata, d);
      end
      chk("wr_fill_we", fill_we, 0);
      chk("wr_resp_valid", resp_valid, 0);
      next_cycle();
    end
    mem_model[a] = d;
    quiet();
  endtask

  // Ungranted read: abandoned once it has waited TMO cycles past its first request cycle.
  task automatic read_timeout(input logic [31:0] a);
    for (int c = 0; c <= int'(TMO) + 2; c++) begin
      quiet();
      if (c == 0) begin
        req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; req_addr = a;
      end else if (c <= int'(TMO)) begin
        junk_req();
      end
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge clk);
      chk("tmo_stall", stall, (c <= int'(TMO) + 1));
      chk("tmo_mem_req", mem_req, (c >= 1 && c <= int'(TMO) + 1));
      chk("tmo_resp_valid", resp_valid, (c == int'(TMO) + 1));
      if (c == int'(TMO) + 1) chk("tmo_resp_rdata", resp_rdata, 0);
      chk("tmo_fill_we", fill_we, 0);
      chk("tmo_flag", timeout, (c >= int'(TMO) + 2));
      next_cycle();
    end
    timeout_exp = 1'b1;
    quiet();
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    quiet();
    @(negedge clk);
    chk_all_zero(tag);
    next_cycle();
    rst = 1'b0;
    timeout_exp = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    @(negedge clk);
    chk_all_zero("reset");
    next_cycle();
    rst = 1'b0;

    read_hit(32'h0000_0040);

    mem_model[32'h0000_1234] = 32'hDEAD_BEEF;
    read_miss(32'h0000_1234, 1, 3);

    store(32'h0000_0080, 32'hCAFE_F00D, 2);
    read_miss(32'h0000_0080, 2, 2);

    read_miss(32'h0000_2000, 1, 1);

    read_timeout(32'h0000_0300);
    read_hit(32'h0000_0044);
    store(32'h0000_0304, 32'h1357_9BDF, 1);
    read_hit(32'h0000_0048);
    pulse_reset("rst_after_tmo");

    // Reset while waiting for read data, then a stray late rvalid.
    req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; req_addr = 32'h0000_0500;
    next_cycle();
    quiet();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rw_stall", stall, 1);
    chk("rw_mem_req", mem_req, 0);
    next_cycle();
    pulse_reset("rst_mid");
    for (int c = 0; c < 3; c++) begin
      mem_rvalid = (c == 0);
      mem_rdata  = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("post_rst_resp_valid", resp_valid, 0);
      chk("post_rst_fill_we", fill_we, 0);
      chk("post_rst_mem_req", mem_req, 0);
      chk("post_rst_stall", stall, 0);
      next_cycle();
    end
    quiet();

    for (int n = 0; n < 60; n++) begin
      int unsigned kind, g, r;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      g    = $urandom_range(1, 4);
      r    = g + $urandom_range(0, 3);
      case (kind)
        0: read_hit(a);
        1: read_miss(a, int'(g), int'(r));
        default: store(a, $urandom, int'($urandom_range(1, 5)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss handler and write-through controller placed directly downstream of the 4-way set-associative data cache, between the cache and main data memory. On a read miss it stalls the pipeline, fetches the word from memory over a request/grant/rvalid handshake, returns it to the pipeline and installs it in the cache. Every store is also forwarded to memory, which keeps memory coherent without dirty bits. A watchdog aborts any memory transaction that never completes.

## Interface
- `DATA_WIDTH`, 32: data word width.
- `ADDR_WIDTH`, 32: byte address width.
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting in one memory state before abort.

- `clk_i`  in  1  clock. All flops are posedge-triggered.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  pipeline memory access this cycle.
- `req_we_i`  in  1  access is a store.
- `req_addr_i`  in  ADDR_WIDTH  access byte address.
- `req_wdata_i`  in  DATA_WIDTH  store data.
- `hit_i`  in  1  cache hit flag from the cache (combinational).
- `stall_o`  out  1  freeze the pipeline.
- `resp_valid_o`  out  1  one-cycle pulse: `resp_rdata_o` holds the refilled read data.
- `resp_rdata_o`  out  DATA_WIDTH  refilled read data.
- `fill_we_o`  out  1  cache write enable, drives the cache's write port.
- `fill_addr_o`  out  ADDR_WIDTH  cache fill address.
- `fill_data_o`  out  DATA_WIDTH  cache fill data.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  memory request is a write.
- `mem_addr_o`  out  ADDR_WIDTH  memory address.
- `mem_wdata_o`  out  DATA_WIDTH  memory write data.
- `mem_gnt_i`  in  1  memory accepted the request this cycle.
- `mem_rvalid_i`  in  1  memory read data valid.
- `mem_rdata_i`  in  DATA_WIDTH  memory read data.
- `timeout_o`  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ.
- IDLE transitions:
  - `req_valid_i & ~req_we_i & ~hit_i` → RD_REQ; latch address.
  - `req_valid_i & req_we_i` → WR_REQ; latch address and data.
  - Read hit: stay in IDLE. The cache serves the data.
- RD_REQ:
  - Drive `mem_req_o=1`, `mem_we_o=0`, latched address.
  - `mem_gnt_i & mem_rvalid_i` → FILL, capturing `mem_rdata_i`.
  - `mem_gnt_i` alone → RD_WAIT.
- RD_WAIT: on `mem_rvalid_i`, capture data → FILL. `mem_req_o=0`.
- FILL, one cycle, then → IDLE:
  - `fill_we_o=1`, `fill_addr_o`/`fill_data_o` = latched address and data.
  - `resp_valid_o=1`, `resp_rdata_o` = latched data.
- WR_REQ:
  - Drive `mem_req_o=1`, `mem_we_o=1`, latched address and data.
  - On `mem_gnt_i` → IDLE. Writes are posted; no rvalid is expected.
  - The cache performs its own store update; `fill_we_o` stays 0.
- `stall_o`:
  - IDLE: `stall_o` = `req_valid_i & (req_we_i | ~hit_i)`, combinational.
  - RD_REQ, RD_WAIT, WR_REQ: `stall_o` = 1.
  - FILL: `stall_o` = 0, so the pipeline consumes `resp_rdata_o` on that edge.
- `req_*` inputs are ignored outside IDLE.
- Watchdog (RD_REQ, RD_WAIT, WR_REQ):
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It clears on every state change and saturates.
  - When the count reaches `TIMEOUT_CYCLES`, set `timeout_o` and go to IDLE.
  - If the aborted transaction was a read, also pulse `resp_valid_o` with `resp_rdata_o=0`. No cache fill occurs.
- `mem_rvalid_i` is ignored in IDLE, WR_REQ and FILL.

## Timing
- Reset values: state IDLE; all outputs 0; latched address, data and counter 0.
- Reset asserted mid-transaction: return to IDLE immediately, drop `mem_req_o`. Any late `mem_rvalid_i` after reset is ignored.
- Read-miss latency, with gnt at request cycle +g and rvalid at +r (r > g): FILL occurs at cycle r+1. With a same-cycle gnt/rvalid at cycle 1, FILL is at cycle 2, giving a minimum 2-cycle stall.
- Store with immediate grant: `stall_o` high in cycles 0 and 1; back in IDLE at cycle 2.
- `fill_we_o` is high for a full posedge-to-posedge cycle. The cache samples it at the intervening negedge.
- All memory-side outputs are state-decoded only; they have no combinational path from `req_*`.

## Structure
- Shared package `cache_pkg`:
  - `refill_state_t` enum.
  - Set/tag width constants (`SET_BITS=4`, `TAG_BITS=26`), shared with the cache.
- One sub-module, `refill_timer`: the saturating watchdog counter with clear, enable and `expired` output.
- Everything else lives in the FSM module.

## Test plan
- Read hit at 0x40 with `hit_i=1` → `stall_o=0`, no `mem_req_o`, state stays IDLE.
- Read miss at 0x1234, gnt at cycle 1, rvalid at cycle 3 with 0xDEADBEEF → FILL at cycle 4: `fill_we_o=1`, `fill_addr_o=0x1234`, `resp_rdata_o=0xDEADBEEF`, `stall_o` high in cycles 0–3.
- Store 0xCAFEF00D to 0x80, gnt at cycle 2 → `mem_we_o=1` with that address/data held in cycles 1–2, IDLE at cycle 3, `fill_we_o` never asserted.
- Read miss with no gnt, `TIMEOUT_CYCLES=8` → after 8 cycles in RD_REQ: `timeout_o=1` (sticky), `resp_valid_o` pulse with data 0, no fill.
- `rst_i` pulsed during RD_WAIT, then stray `mem_rvalid_i` → all outputs 0, no `resp_valid_o` and no `fill_we_o`.
- Same-cycle `mem_gnt_i` and `mem_rvalid_i` in RD_REQ → goes directly to FILL, skipping RD_WAIT.
